// File: rtl/prog_loader.sv
// Streams a program image into instruction memory, then releases the core
// from reset after a fixed hold period. Overflowing images latch an error.
module prog_loader #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              overflow_err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {LOAD, HOLD, RUN, ERR} state_t;

  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [7:0]      HOLD_INIT = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic       beat;

  assign beat = s_valid && s_ready;

  // s_ready is a flop so it stays low through reset and rises on the first
  // edge after release; it always tracks the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= LOAD;
      hold_cnt     <= '0;
      s_ready      <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst     <= 1'b0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
      word_count   <= '0;
    end else begin
      imem_we <= beat;
      if (beat) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= s_data;
        word_count <= word_count + (ADDR_W+1)'(1);
      end
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (beat) begin
            if (s_last) begin
              state    <= HOLD;
              hold_cnt <= HOLD_INIT;
              s_ready  <= 1'b0;
            end else if (word_count == LAST_IDX) begin
              state        <= ERR;
              overflow_err <= 1'b1;
              s_ready      <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state     <= RUN;
            core_rst  <= 1'b1;
            load_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        RUN, ERR: begin
          if (reload) begin
            state        <= LOAD;
            s_ready      <= 1'b1;
            core_rst     <= 1'b0;
            load_done    <= 1'b0;
            overflow_err <= 1'b0;
            word_count   <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (DEPTH=4) with a cycle-timestamp reference
// model compared on every falling edge, plus literal spot checks.
module tb_prog_loader;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int HOLD  = 4;

  logic          clk = 1'b0;
  logic          rst, s_valid, s_last, reload;
  logic [31:0]   s_data;
  logic          s_ready, imem_we, core_rst, load_done, overflow_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;

  int checks = 0;
  int failures = 0;

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .reload(reload),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .load_done(load_done),
    .overflow_err(overflow_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: loading/fault flags, word count, and the absolute cycle
  // at which the core is released (strobe cycle + HOLD).
  int          cyc = 0;
  int          run_at = 1 << 30;
  bit          m_loading = 1'b1, m_fault = 1'b0, m_edge = 1'b0, m_we = 1'b0;
  int          m_count = 0, m_addr = 0;
  logic [31:0] m_data = '0;

  function automatic bit m_run();
    return !m_loading && !m_fault && (cyc >= run_at);
  endfunction

  always @(posedge clk or negedge rst) begin
    bit acc, was_run;
    if (!rst) begin
      m_loading = 1'b1; m_fault = 1'b0; m_edge = 1'b0; m_we = 1'b0;
      m_count = 0; m_addr = 0; m_data = '0; run_at = 1 << 30;
    end else begin
      acc     = s_valid && m_edge && m_loading;
      was_run = m_run();
      cyc++;
      m_we   = acc;
      m_edge = 1'b1;
      if (acc) begin
        m_addr = m_count;
        m_data = s_data;
        if (s_last) begin
          m_loading = 1'b0;
          run_at = cyc + HOLD;
        end else if (m_count == DEPTH - 1) begin
          m_loading = 1'b0;
          m_fault = 1'b1;
        end
        m_count++;
      end else if (reload && (was_run || m_fault)) begin
        m_loading = 1'b1; m_fault = 1'b0; m_count = 0; run_at = 1 << 30;
      end
    end
  end

  always @(negedge clk) begin
    chk("s_ready", 32'(s_ready), 32'(m_edge && m_loading));
    chk("core_rst", 32'(core_rst), 32'(m_run()));
    chk("load_done", 32'(load_done), 32'(m_run()));
    chk("overflow_err", 32'(overflow_err), 32'(m_fault));
    chk("word_count", 32'(word_count), 32'(m_count));
    chk("imem_we", 32'(imem_we), 32'(m_we));
    if (m_we || !rst) begin
      chk("imem_addr", 32'(imem_addr), 32'(m_addr));
      chk("imem_wdata", imem_wdata, m_data);
    end
  end

  // Strobe / release monitor used by the literal checks.
  int          ncyc = 0, last_strobe = 0, rise_at = 0;
  bit          prev_core = 1'b0;
  logic [31:0] saddr[$];
  logic [31:0] sdata[$];

  always @(negedge clk) begin
    ncyc++;
    if (imem_we) begin
      saddr.push_back(32'(imem_addr));
      sdata.push_back(imem_wdata);
      last_strobe = ncyc;
    end
    if (core_rst && !prev_core) rise_at = ncyc;
    prev_core = core_rst;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_run();
    for (int k = 0; k < 30 && !load_done; k++) tick();
    chk("run_timeout", 32'(load_done), 32'd1);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    saddr.delete();
    sdata.delete();
  endtask

  logic [31:0] prog [3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; reload = 1'b0;
    repeat (2) tick();
    chk("rst_core_rst", 32'(core_rst), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("ready_after_rst", 32'(s_ready), 32'd1);

    // Three-word image, valid held high
    saddr.delete(); sdata.delete();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = prog[i]; s_last = (i == 2);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    wait_run();
    chk("t1_nstrobe", 32'(saddr.size()), 32'd3);
    for (int i = 0; i < 3 && i < saddr.size(); i++) begin
      chk("t1_addr", saddr[i], 32'(i));
      chk("t1_data", sdata[i], prog[i]);
    end
    chk("t1_hold", 32'(rise_at - last_strobe), 32'd4);
    chk("t1_count", 32'(word_count), 32'd3);
    chk("t1_done", 32'(load_done), 32'd1);

    // Reload from RUN, one-word image
    do_reload();
    chk("t2_core_rst", 32'(core_rst), 32'd0);
    chk("t2_count_clr", 32'(word_count), 32'd0);
    s_valid = 1'b1; s_data = 32'h00100093; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    wait_run();
    chk("t2_nstrobe", 32'(saddr.size()), 32'd1);
    if (saddr.size() > 0) chk("t2_addr", saddr[0], 32'd0);
    chk("t2_count", 32'(word_count), 32'd1);
    chk("t2_hold", 32'(rise_at - last_strobe), 32'd4);

    // Gapped valid; reload pulsed during HOLD is ignored
    do_reload();
    for (int i = 0; i < 4; i++) begin
      s_valid = (i % 2 == 0); s_data = 32'hA000_0000 + 32'(i); s_last = (i == 2);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    wait_run();
    chk("t3_nstrobe", 32'(saddr.size()), 32'd2);
    if (saddr.size() == 2) begin
      chk("t3_addr0", saddr[0], 32'd0);
      chk("t3_addr1", saddr[1], 32'd1);
      chk("t3_data1", sdata[1], 32'hA000_0002);
    end
    chk("t3_hold", 32'(rise_at - last_strobe), 32'd4);

    // Exact fill: DEPTH words, last on the final one
    do_reload();
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_data = 32'hB000_0000 + 32'(i); s_last = (i == DEPTH - 1);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    wait_run();
    chk("t4_overflow", 32'(overflow_err), 32'd0);
    chk("t4_count", 32'(word_count), 32'd4);
    chk("t4_nstrobe", 32'(saddr.size()), 32'd4);
    if (saddr.size() == 4) chk("t4_addr3", saddr[3], 32'd3);

    // Overflow: 5 words, no last; reload coincident with first beat
    do_reload();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 32'hC000_0000 + 32'(i); s_last = 1'b0; reload = (i == 0);
      tick();
    end
    s_valid = 1'b0; reload = 1'b0;
    repeat (3) tick();
    chk("t5_nstrobe", 32'(saddr.size()), 32'd4);
    chk("t5_overflow", 32'(overflow_err), 32'd1);
    chk("t5_ready", 32'(s_ready), 32'd0);
    chk("t5_core_rst", 32'(core_rst), 32'd0);
    chk("t5_count", 32'(word_count), 32'd4);

    // Reset mid-HOLD
    do_reload();
    chk("t6_err_clr", 32'(overflow_err), 32'd0);
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 32'hD000_0000 + 32'(i); s_last = (i == 1);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_we", 32'(imem_we), 32'd0);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    chk("t6_wdata", imem_wdata, 32'd0);
    chk("t6_count", 32'(word_count), 32'd0);
    chk("t6_ready", 32'(s_ready), 32'd0);
    chk("t6_core_rst", 32'(core_rst), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_ready_after", 32'(s_ready), 32'd1);
    chk("t6_count_after", 32'(word_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL take parameter DEPTH, default 256, as the instruction-memory capacity in 32-bit words (power of two, ≥4).
REQ-002 The block SHALL take parameter ADDR_W, default 8, as the word-address width, with 2^ADDR_W = DEPTH.
REQ-003 The block SHALL take parameter HOLD_CYCLES, default 4, as the number of cycles the core stays in reset after the final write, range 1..255.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low.
REQ-006 s_valid  in  1  program word available on s_data.
REQ-007 s_ready  out  1  loader accepts a word this cycle.
REQ-008 s_data  in  32  program word, little-endian RV32I instruction.
REQ-009 s_last  in  1  marks the final word of the image.
REQ-010 reload  in  1  single-cycle request to restart loading.
REQ-011 imem_we  out  1  instruction-memory write strobe.
REQ-012 imem_addr  out  ADDR_W  word address of the write.
REQ-013 imem_wdata  out  32  write data.
REQ-014 core_rst  out  1  active-low reset to the pipelined core; 0 holds the core in reset.
REQ-015 load_done  out  1  image loaded and core running.
REQ-016 overflow_err  out  1  sticky: image exceeded DEPTH words.
REQ-017 word_count  out  ADDR_W+1  words accepted since the last load start.

Function
REQ-018 The FSM SHALL have the states LOAD, HOLD, RUN and ERR.
REQ-019 A beat SHALL transfer only when s_valid=1 and s_ready=1 in the same cycle.
REQ-020 s_ready SHALL be 1 only in LOAD and SHALL be combinationally independent of s_valid.
REQ-021 An accepted beat SHALL produce imem_we=1 in the following cycle, with imem_addr=word_count (pre-increment value) and imem_wdata=s_data, both registered: 1-cycle latency, one strobe per beat.
REQ-022 imem_we SHALL be 0 in every cycle not following an accepted beat.
REQ-023 word_count SHALL increment by 1 per accepted beat and SHALL never wrap.
REQ-024 LOAD->HOLD SHALL occur on an accepted beat with s_last=1 when word_count<DEPTH before the beat.
REQ-025 LOAD->ERR SHALL occur on an accepted beat with s_last=0 when word_count=DEPTH-1 before the beat: the beat is written, and overflow_err is set in the next cycle.
REQ-026 A beat with s_last=1 at word_count=DEPTH-1 SHALL go to HOLD with no error (exact fill).
REQ-027 HOLD SHALL last exactly HOLD_CYCLES cycles, counted from the cycle in which the last write strobe occurs, and SHALL then enter RUN.
REQ-028 In RUN, core_rst=1 and load_done=1; in all other states both are 0.
REQ-029 ERR SHALL hold core_rst=0 and s_ready=0 until reload or reset.
REQ-030 reload=1 in RUN or ERR SHALL, at the next edge, enter LOAD, drive core_rst=0 and load_done=0, clear word_count and clear overflow_err.
REQ-031 reload SHALL be ignored in LOAD and HOLD.
REQ-032 When reload and an accepted beat fall in the same cycle, reload SHALL be ignored and the beat SHALL proceed.
REQ-033 core_rst SHALL be glitch-free, driven directly from a flop.

Reset
REQ-034 While rst=0, the block SHALL asynchronously force state=LOAD, word_count=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=0, load_done=0, overflow_err=0 and the HOLD counter to 0.
REQ-035 s_ready SHALL be 0 while rst=0 and SHALL become 1 in the first cycle after rst deasserts.
REQ-036 A reset asserted during LOAD or HOLD SHALL abandon the transfer; a pending write strobe SHALL NOT be issued.

Verification
REQ-037 Stream 3 words 0x00500093, 0x00A00113, 0x002081B3 (last on the 3rd), s_valid held high -> imem_we on cycles 2-4 at addresses 0,1,2; core_rst rises 4 cycles after the 3rd strobe; word_count=3; load_done=1.
REQ-038 Toggle s_valid 1,0,1,0 with 2 words -> exactly 2 strobes at addresses 0,1; no duplicate writes.
REQ-039 With DEPTH=4, send 5 words and no s_last -> 4 writes; ERR with overflow_err=1 and s_ready=0; 5th word not accepted; core_rst stays 0.
REQ-040 With DEPTH=4, send 4 words with s_last on the 4th -> HOLD then RUN; overflow_err=0.
REQ-041 In RUN, pulse reload, then send 1 word with last -> core_rst=0 the next cycle; word_count=1; write at address 0; RUN after HOLD_CYCLES.
REQ-042 Assert rst mid-HOLD after 2 words -> all outputs return to reset values immediately; after release, s_ready=1 and word_count=0.
